// File: rtl/mccpu.sv
// Multi-cycle MIPS-subset CPU with one shared memory port.
// Five-state FSM: FETCH, DECODE, EXEC, MEM, WB.
module mccpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic        retire,
  output logic        illegal,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
  } state_t;

  state_t state, state_n;

  logic [31:0] pc, ir, a, b;
  logic [31:0] alu_out, mdr, alu_res;
  logic [31:0] regs [NUM_REGS];

  logic [5:0]    op, fn;
  logic [AW-1:0] rs, rt, rd, wb_idx;
  logic [4:0]    shamt;
  logic [31:0]   imm_s, imm_z, br_off, wb_data;

  assign op    = ir[31:26];
  assign fn    = ir[5:0];
  assign rs    = ir[21 +: AW];
  assign rt    = ir[16 +: AW];
  assign rd    = ir[11 +: AW];
  assign shamt = ir[10:6];
  assign imm_s = {{16{ir[15]}}, ir[15:0]};
  assign imm_z = {16'h0, ir[15:0]};
  assign br_off = {imm_s[29:0], 2'b00};

  logic is_r, r_addu, r_subu, r_and, r_or;
  logic r_slt, r_sll, r_srl, r_ok;
  logic is_addi, is_addiu, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, legal;

  assign is_r     = (op == 6'h00);
  assign r_addu   = is_r && (fn == 6'h21);
  assign r_subu   = is_r && (fn == 6'h23);
  assign r_and    = is_r && (fn == 6'h24);
  assign r_or     = is_r && (fn == 6'h25);
  assign r_slt    = is_r && (fn == 6'h2A);
  assign r_sll    = is_r && (fn == 6'h00);
  assign r_srl    = is_r && (fn == 6'h02);
  assign r_ok     = r_addu | r_subu | r_and | r_or
                  | r_slt | r_sll | r_srl;
  assign is_addi  = (op == 6'h08);
  assign is_addiu = (op == 6'h09);
  assign is_ori   = (op == 6'h0D);
  assign is_lui   = (op == 6'h0F);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign legal    = r_ok | is_addi | is_addiu | is_ori
                  | is_lui | is_lw | is_sw | is_beq | is_j;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      r_addu:  alu_res = a + b;
      r_subu:  alu_res = a - b;
      r_and:   alu_res = a & b;
      r_or:    alu_res = a | b;
      r_slt:   alu_res = {31'h0, $signed(a) < $signed(b)};
      r_sll:   alu_res = b << shamt;
      r_srl:   alu_res = b >> shamt;
      is_addi, is_addiu, is_lw, is_sw:
               alu_res = a + imm_s;
      is_ori:  alu_res = a | imm_z;
      is_lui:  alu_res = {ir[15:0], 16'h0};
      default: alu_res = '0;
    endcase
  end

  assign wb_idx    = is_r ? rd : rt;
  assign wb_data   = is_lw ? mdr : alu_out;
  assign mem_wdata = b;
  assign PC        = pc;
  assign reg_data  = (int'(reg_sel) < NUM_REGS)
                   ? regs[reg_sel[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    retire   = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_n = DECODE;
      end
      DECODE: begin
        if (is_j || !legal) begin
          retire  = 1'b1;
          illegal = !legal;
          state_n = FETCH;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (is_beq) begin
          retire  = 1'b1;
          state_n = FETCH;
        end else if (is_lw || is_sw) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = alu_out;
        if (mem_ready) begin
          retire  = is_sw;
          state_n = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        retire  = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // Reset abandons any in-flight access immediately
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
          if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        EXEC: begin
          alu_out <= alu_res;
          if (is_beq && a == b) pc <= pc + br_off;
        end
        MEM: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == WB && wb_idx != '0) begin
      regs[wb_idx] <= wb_data;
    end
  end

endmodule
